// File: rtl/rev_pkg.sv
// Shared types and constants for the reversible gate sequencer.
// Working width and program depth are fixed here; every other file imports them.
package rev_pkg;

  localparam int W     = 5;                // working register width
  localparam int DEPTH = 8;                // program store entries
  localparam int AW    = $clog2(DEPTH);    // program address width
  localparam int CW    = $clog2(W);        // control index width
  localparam int XW    = 2 ** CW;          // control index range, padded to a power of two

  // One multi-target controlled-XOR gate: flip tmask when bits c0 and c1 are both set.
  typedef struct packed {
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    logic [W-1:0]  tmask;
  } gate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requested run lengths beyond the store size execute the whole store once.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : l;
  endfunction

endpackage

// File: rtl/rev_gate_sequencer_if.sv
// Command, program-write and status signals between the control unit and the sequencer.
interface rev_gate_sequencer_if;
  import rev_pkg::*;

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [CW-1:0] prog_c0;
  logic [CW-1:0] prog_c1;
  logic [W-1:0]  prog_tmask;

  logic          start;
  logic          dir;
  logic [AW:0]   len;
  logic [W-1:0]  din;

  logic [W-1:0]  dout;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output prog_we, prog_addr, prog_c0, prog_c1, prog_tmask,
    output start, dir, len, din,
    input  dout, busy, done, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_c0, prog_c1, prog_tmask,
    input  start, dir, len, din,
    output dout, busy, done, err
  );

endinterface

// File: rtl/rev_mct_gate.sv
// Combinational evaluator for one MCT gate, time-shared across the whole program.
// Optional macro REVSEQ_CHECK_EN adds the illegal-gate output; illegal gates become no-ops.
module rev_mct_gate
  import rev_pkg::*;
(
  input  logic [W-1:0] reg_in,
  input  gate_t        gate,
  output logic [W-1:0] reg_out
`ifdef REVSEQ_CHECK_EN
  ,
  output logic         illegal
`endif
);

  logic [XW-1:0] reg_ext;
  logic          ctl0;
  logic          ctl1;
  logic          fire;
`ifdef REVSEQ_CHECK_EN
  logic [XW-1:0] mask_ext;
`endif

  // Zero-padding the operand makes any control index >= W read as 0 without a compare.
  always_comb begin
    reg_ext          = '0;
    reg_ext[W-1:0]   = reg_in;
    ctl0             = reg_ext[gate.c0];
    ctl1             = reg_ext[gate.c1];
`ifdef REVSEQ_CHECK_EN
    mask_ext         = '0;
    mask_ext[W-1:0]  = gate.tmask;
    // A target overlapping a control, or an out-of-range control, would break reversibility.
    illegal          = (int'(gate.c0) >= W) | (int'(gate.c1) >= W) |
                       mask_ext[gate.c0] | mask_ext[gate.c1];
    fire             = ctl0 & ctl1 & ~illegal;
`else
    fire             = ctl0 & ctl1;
`endif
    reg_out          = fire ? (reg_in ^ gate.tmask) : reg_in;
  end

endmodule

// File: rtl/rev_gate_sequencer.sv
// Applies a stored MCT gate program to a loaded operand, one gate per clock,
// forward (entry 0 upward) or reverse (entry len-1 downward).
// Optional macro REVSEQ_CHECK_EN enables illegal-gate detection and the sticky err flag.
module rev_gate_sequencer
  import rev_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rev_gate_sequencer_if.slave  bus
);

  state_t        state_q, state_d;
  logic [W-1:0]  reg_q, reg_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  gate_t         prog_q [DEPTH];
  gate_t         prog_d [DEPTH];

  logic [AW:0]   len_c;
  logic [AW:0]   last_c;
  gate_t         cur_gate;
  logic [W-1:0]  gate_out;
`ifdef REVSEQ_CHECK_EN
  logic          err_q, err_d;
  logic          gate_illegal;
`endif

  assign len_c    = clamp_len(bus.len);
  assign last_c   = len_c - (AW+1)'(1);
  assign cur_gate = prog_q[idx_q];

  rev_mct_gate u_gate (
    .reg_in  (reg_q),
    .gate    (cur_gate),
    .reg_out (gate_out)
`ifdef REVSEQ_CHECK_EN
    ,
    .illegal (gate_illegal)
`endif
  );

  // Program store update: writes are dropped while a run is in progress.
  always_comb begin
    prog_d = prog_q;
    if (bus.prog_we && !busy_q) begin
      prog_d[bus.prog_addr].c0    = bus.prog_c0;
      prog_d[bus.prog_addr].c1    = bus.prog_c1;
      prog_d[bus.prog_addr].tmask = bus.prog_tmask;
    end
  end

  // Program store registers; reset leaves every entry as the identity gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) prog_q[i] <= '0;
    end else begin
      prog_q <= prog_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      reg_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REVSEQ_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REVSEQ_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: a zero-length run goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (len_c == '0) ? DONE : RUN;
      RUN:  if (cnt_q == (AW+1)'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status: load on start, one gate per RUN cycle, flags follow next state.
  always_comb begin
    reg_d = reg_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
`ifdef REVSEQ_CHECK_EN
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          reg_d = bus.din;
          cnt_d = len_c;
          dir_d = bus.dir;
          idx_d = bus.dir ? last_c[AW-1:0] : '0;
`ifdef REVSEQ_CHECK_EN
          err_d = 1'b0;
`endif
        end
      end
      RUN: begin
        reg_d = gate_out;
        idx_d = dir_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
        cnt_d = cnt_q - (AW+1)'(1);
`ifdef REVSEQ_CHECK_EN
        err_d = err_q | gate_illegal;
`endif
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.dout = reg_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef REVSEQ_CHECK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: doc/rev_gate_sequencer.md
# rev_gate_sequencer

Sequencer for multi-target controlled-XOR (MCT) reversible gates. It holds a W-bit working register and a small program store of gate descriptors. On command it applies the stored sequence to a loaded operand, one gate per cycle, either forward or in reverse order. Because every MCT gate is self-inverse, a reverse run undoes a forward run. It sits between the control unit and the reversible ALU datapath, sharing one gate evaluator across the whole sequence.

## Interface
- W, 5, working register width
- DEPTH, 8, program store entries; AW = $clog2(DEPTH), CW = $clog2(W)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- prog_we  in  1  write program entry at prog_addr (ignored while busy)
- prog_addr  in  AW  entry index
- prog_c0, prog_c1  in  CW each  control bit indices
- prog_tmask  in  W  target mask
- start  in  1  begin run (ignored while busy)
- dir  in  1  0 = forward (entry 0 upward), 1 = reverse (entry len-1 downward)
- len  in  AW+1  number of gates; values above DEPTH clamp to DEPTH
- din  in  W  operand
- dout  out  W  working register (final result when done)
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- err  out  1  illegal-gate flag (only with REVSEQ_CHECK_EN; otherwise tied 0)

## Operation
- Gate semantics: if reg[c0] & reg[c1], then reg ^= tmask; otherwise reg is unchanged. c0 == c1 is legal and acts as a single control.
- States:
  - IDLE: on start, load reg←din, cnt←clamped len, idx←0 (fwd) or len-1 (rev), clear err. Go to DONE if len==0, else RUN.
  - RUN: apply entry idx each cycle; idx ±1, cnt−1. Go to DONE when cnt reaches 1.
  - DONE: pulse done for one cycle, then return to IDLE.
- Control index ≥ W reads as 0, so the gate never fires.
- Program store is a register array with combinational read. A write to an entry in the same cycle it is read takes effect on the next read only.
- prog_we and start are both dropped while busy; they are not queued.
- reset: reg, idx, cnt, busy, done and err go to 0; the state goes to IDLE. Every program entry clears to c0=0, c1=0, tmask=0 (identity gate). A reset mid-run aborts the run with no done pulse.

## Timing
- start is sampled on edge t0. Gates are applied on edges t1..t_len. done is high during the cycle after t_len. Latency from start to done is len+1 cycles; with len==0 it is 1 cycle.
- busy is high from t0+1 through the done cycle inclusive. A start raised in the done cycle is ignored; the earliest accepted start is the following cycle.
- dout changes only on load and on gate edges. It is stable from the done cycle until the next accepted start.

## Configuration
- REVSEQ_CHECK_EN defined: a gate is illegal if tmask has the c0 or c1 bit set, or if c0/c1 ≥ W. An illegal gate is executed as a no-op and sets err sticky until the next accepted start. This keeps the run reversible.
- Not defined: no checking is done, err is tied 0, and overlapping masks are applied as written. The result may not be reversible.

## Structure
- Shared package rev_pkg:
  - gate_t struct {c0, c1, tmask}
  - state enum {IDLE, RUN, DONE}
  - default W/DEPTH constants
- Sub-module rev_mct_gate: purely combinational, takes (reg, gate_t) and returns the new reg (plus an illegal flag under REVSEQ_CHECK_EN). It is instantiated once and time-shared by the sequencer.

## Test plan
- Entry0 = {c0=0, c1=1, tmask=11100}, len=1, fwd, din=00011 → dout=11111, done 2 cycles after start; din=00001 → dout=00001.
- Three-entry program, fwd on din=10110 gives result R; rev run with din=R → dout=10110.
- len=0, din=01010 → done 1 cycle after start, dout=01010, busy high for exactly 1 cycle.
- start and prog_we pulsed mid-run (len=4) → run unchanged, program unchanged, exactly one done.
- rst_n low at gate 2 of a 4-gate run → dout=0, busy=0, no done, all entries read back as identity.
- With REVSEQ_CHECK_EN: entry {c0=2, c1=3, tmask=00100}, din=01100 → dout=01100, err=1; the next start clears err.
